amer_put_ctrl: RTL

Host-side control stage directly upstream and downstream of amer_put. It loads the five IEEE-754 double lattice parameters over an 8-bit byte stream (UART/JTAG bridge) and drives them to amer_put as static registers. On a run command it sequences start_s1 and start_s2 with fixed cycle budgets, captures amer_put.result, and streams the result back out as 8 bytes.

---
 rtl/amer_put_pkg.sv | 29 ++
 rtl/amer_put_byte_ser.sv | 39 +++
 rtl/amer_put_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/amer_put_pkg.sv
// Shared constants for the amer_put host control stage: command bytes, FSM states
// and the IEEE-754 encoding of 1.0 used as the K_over_S reset value.
package amer_put_pkg;

    localparam logic [7:0] CMD_P_UP         = 8'h01;
    localparam logic [7:0] CMD_P_DOWN       = 8'h02;
    localparam logic [7:0] CMD_LL_UP        = 8'h03;
    localparam logic [7:0] CMD_LL_DOWN      = 8'h04;
    localparam logic [7:0] CMD_K_OVER_S     = 8'h05;
    localparam logic [7:0] CMD_RUN          = 8'h10;

    localparam logic [63:0] DBL_ONE         = 64'h3ff0000000000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START1,
        ST_WAIT1,
        ST_START2,
        ST_WAIT2,
        ST_CAPTURE,
        ST_SEND
    } state_t;

    function automatic logic is_load_cmd(input logic [7:0] b);
        return (b >= CMD_P_UP) && (b <= CMD_K_OVER_S);
    endfunction

endpackage

// File: rtl/amer_put_byte_ser.sv
// 64-bit parallel-in / byte-out serializer, MSB first; first byte valid the cycle after load.
// Holds o_dat stable while i_rdy is low; one byte per cycle when i_rdy stays high.
module amer_put_byte_ser (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_load,
    input  logic [63:0] i_word,
    output logic [7:0]  o_dat,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic        o_done
);

    logic [63:0] r_word;
    logic [2:0]  r_idx;
    logic        r_vld;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_word <= '0;
            r_idx  <= '0;
            r_vld  <= 1'b0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
            r_vld  <= 1'b1;
        end else if (r_vld && i_rdy) begin
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7)
                r_vld <= 1'b0;
        end
    end

    // Index 0 selects bits 63:56, so the byte offset is (7 - idx) * 8.
    assign o_dat  = r_word[{~r_idx, 3'b000} +: 8];
    assign o_vld  = r_vld;
    assign o_done = r_vld && i_rdy && (r_idx == 3'd7);

endmodule

// File: rtl/amer_put_ctrl.sv
// Host control for amer_put: byte-loaded parameter registers, timed start_s1/start_s2
// sequencing, result capture and byte stream-out; in_ready low while a run is in flight.
module amer_put_ctrl
    import amer_put_pkg::*;
#(
    parameter int S1_CYCLES = 8050,
    parameter int S2_CYCLES = 8050,
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] p_up,
    output logic [63:0] p_down,
    output logic [63:0] log_lambda_up,
    output logic [63:0] log_lambda_down,
    output logic [63:0] K_over_S,
    output logic        start_s1,
    output logic        start_s2,
    input  logic [63:0] result,
    output logic        busy
);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_cmd;
    logic [2:0]    r_bcnt;
    logic [55:0]   r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]   r_p_up;
    logic [63:0]   r_p_down;
    logic [63:0]   r_ll_up;
    logic [63:0]   r_ll_down;
    logic [63:0]   r_k_over_s;

    logic          w_in_xfer;
    logic          w_last_byte;
    logic [63:0]   w_word;
    logic          w_cnt_done;
    logic          w_capture;
    logic          w_ser_done;

    assign w_in_xfer   = in_valid && in_ready;
    assign w_word      = {r_shift, in_data};
    assign w_last_byte = (r_state == ST_LOAD) && w_in_xfer && (r_bcnt == 3'd7);
    assign w_cnt_done  = ((r_state == ST_WAIT1) && (r_cnt == CNT_W'(S1_CYCLES - 1))) ||
                         ((r_state == ST_WAIT2) && (r_cnt == CNT_W'(S2_CYCLES - 1)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        start_s1  = 1'b0;
        start_s2  = 1'b0;
        busy      = 1'b1;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_in_xfer) begin
                    if (is_load_cmd(in_data))
                        w_next = ST_LOAD;
                    else if (in_data == CMD_RUN)
                        w_next = ST_START1;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_last_byte)
                    w_next = ST_IDLE;
            end
            ST_START1: begin
                start_s1 = 1'b1;
                w_next   = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (w_cnt_done)
                    w_next = ST_START2;
            end
            ST_START2: begin
                start_s2 = 1'b1;
                w_next   = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (w_cnt_done)
                    w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_capture = 1'b1;
                w_next    = ST_SEND;
            end
            ST_SEND: begin
                if (w_ser_done)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Wait counter runs only inside WAIT1/WAIT2 and restarts from zero on every entry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_cnt <= '0;
        else if (((r_state == ST_WAIT1) || (r_state == ST_WAIT2)) && !w_cnt_done)
            r_cnt <= r_cnt + CNT_W'(1);
        else
            r_cnt <= '0;
    end

    // Bytes 1..7 accumulate in r_shift; the target is written only with the 8th byte.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cmd      <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_p_up     <= '0;
            r_p_down   <= '0;
            r_ll_up    <= '0;
            r_ll_down  <= '0;
            r_k_over_s <= DBL_ONE;
        end else if (w_in_xfer) begin
            if (r_state == ST_IDLE) begin
                r_cmd  <= in_data;
                r_bcnt <= '0;
            end else begin
                r_shift <= w_word[55:0];
                r_bcnt  <= r_bcnt + 3'd1;
                if (w_last_byte) begin
                    case (r_cmd)
                        CMD_P_UP:     r_p_up     <= w_word;
                        CMD_P_DOWN:   r_p_down   <= w_word;
                        CMD_LL_UP:    r_ll_up    <= w_word;
                        CMD_LL_DOWN:  r_ll_down  <= w_word;
                        CMD_K_OVER_S: r_k_over_s <= w_word;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign p_up            = r_p_up;
    assign p_down          = r_p_down;
    assign log_lambda_up   = r_ll_up;
    assign log_lambda_down = r_ll_down;
    assign K_over_S        = r_k_over_s;

    amer_put_byte_ser u_ser (
        .clk    (clk),
        .i_nrst (nrst),
        .i_load (w_capture),
        .i_word (result),
        .o_dat  (out_data),
        .o_vld  (out_valid),
        .i_rdy  (out_ready),
        .o_done (w_ser_done)
    );

endmodule
